// File: rtl/trig_updown_counter.sv
// Trigger-driven up/down counter with prescaled auto-count, bounded range,
// wrap/saturate handling, atomic 16-bit snapshot halves and sticky crossing flags.
module trig_updown_counter #(
    parameter int WIDTH    = 32,
    parameter int PS_WIDTH = 24
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                trig_reset,
    input  logic                trig_up,
    input  logic                trig_down,
    input  logic                trig_load,
    input  logic                trig_capture,
    input  logic                trig_clear,
    input  logic                run_en,
    input  logic                wrap_mode,
    input  logic [15:0]         step,
    input  logic [PS_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]    limit,
    input  logic [WIDTH-1:0]    load_val,
    output logic [WIDTH-1:0]    count,
    output logic [15:0]         snap_lo,
    output logic [15:0]         snap_hi,
    output logic [7:0]          snap_seq,
    output logic                ovf_flag,
    output logic                unf_flag,
    output logic                ev_pulse,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    // Two guard bits so count + step + 1 never overflows and negatives are visible.
    localparam int AW = WIDTH + 2;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [PS_WIDTH-1:0]    ps_q, ps_d;
    logic [15:0]            snap_lo_q, snap_hi_q;
    logic [7:0]             seq_q;
    logic                   ovf_q, unf_q, ev_q;

    logic                   tick;
    logic                   op_active;
    logic                   up_cross, down_cross;
    logic [15:0]            step_eff;
    logic signed [AW-1:0]   step_s, limit_s, tmp;
    logic [WIDTH-1:0]       load_clamped;
    logic [31:0]            cap_val;

    assign tick = (state_q == RUN) && (ps_q == prescale);

    always_comb begin
        step_eff  = (step == '0) ? 16'd1 : step;
        step_s    = {{(AW-16){1'b0}}, step_eff};
        limit_s   = {2'b00, limit};
        tmp       = {2'b00, count_q};
        op_active = !trig_reset && !trig_load && (trig_up || trig_down || tick);
        // Simultaneous up and down cancel; only the tick survives.
        if (trig_up && !trig_down) begin
            tmp = tmp + step_s;
        end
        if (trig_down && !trig_up) begin
            tmp = tmp - step_s;
        end
        if (tick) begin
            tmp = tmp + {{(AW-1){1'b0}}, 1'b1};
        end
        up_cross   = op_active && (tmp > limit_s);
        down_cross = op_active && tmp[AW-1];
    end

    always_comb begin
        load_clamped = (load_val > limit) ? limit : load_val;
        count_d      = count_q;
        if (trig_reset) begin
            count_d = '0;
        end else if (trig_load) begin
            count_d = load_clamped;
        end else if (op_active) begin
            if (up_cross) begin
                count_d = wrap_mode ? '0 : limit;
            end else if (down_cross) begin
                count_d = wrap_mode ? limit : '0;
            end else begin
                count_d = tmp[WIDTH-1:0];
            end
        end else if (count_q > limit) begin
            count_d = limit;
        end
    end

    always_comb begin
        state_d = state_q;
        if (trig_reset) begin
            state_d = run_en ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run_en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!run_en) begin
                        state_d = IDLE;
                    end else if (tick && (up_cross || down_cross) && !wrap_mode) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!run_en) begin
                        state_d = IDLE;
                    end else if (trig_load) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Prescaler only advances while staying in RUN; a lowered prescale wraps it silently.
    always_comb begin
        ps_d = ps_q + {{(PS_WIDTH-1){1'b0}}, 1'b1};
        if (trig_reset || state_q != RUN || state_d != RUN || ps_q >= prescale) begin
            ps_d = '0;
        end
    end

    always_comb begin
        cap_val             = '0;
        cap_val[WIDTH-1:0]  = count_q;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            ps_q      <= '0;
            snap_lo_q <= '0;
            snap_hi_q <= '0;
            seq_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ev_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ps_q    <= ps_d;
            // A same-cycle set beats trig_clear.
            ovf_q   <= up_cross || (ovf_q && !trig_clear);
            unf_q   <= down_cross || (unf_q && !trig_clear);
            ev_q    <= up_cross || down_cross;
            if (trig_capture) begin
                snap_lo_q <= cap_val[15:0];
                snap_hi_q <= cap_val[31:16];
                seq_q     <= seq_q + 8'd1;
            end
        end
    end

    assign count    = count_q;
    assign snap_lo  = snap_lo_q;
    assign snap_hi  = snap_hi_q;
    assign snap_seq = seq_q;
    assign ovf_flag = ovf_q;
    assign unf_flag = unf_q;
    assign ev_pulse = ev_q;
    assign state    = state_q;

endmodule

// File: tb/tb_trig_updown_counter.sv
// Directed bench for trig_updown_counter: vector table for manual counting,
// plus hand sequences for auto-run, snapshots and asynchronous reset.
module tb_trig_updown_counter;

    localparam int WIDTH    = 32;
    localparam int PS_WIDTH = 24;

    localparam logic [5:0] T_UP  = 6'b000001;
    localparam logic [5:0] T_DN  = 6'b000010;
    localparam logic [5:0] T_LD  = 6'b000100;
    localparam logic [5:0] T_CAP = 6'b001000;
    localparam logic [5:0] T_CLR = 6'b010000;
    localparam logic [5:0] T_RST = 6'b100000;

    logic                sys_clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                trig_reset, trig_up, trig_down, trig_load, trig_capture, trig_clear;
    logic                run_en, wrap_mode;
    logic [15:0]         step;
    logic [PS_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]    limit, load_val, count;
    logic [15:0]         snap_lo, snap_hi;
    logic [7:0]          snap_seq;
    logic                ovf_flag, unf_flag, ev_pulse;
    logic [1:0]          state;

    int checks = 0;
    int errors = 0;

    trig_updown_counter #(.WIDTH(WIDTH), .PS_WIDTH(PS_WIDTH)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .trig_reset(trig_reset), .trig_up(trig_up), .trig_down(trig_down),
        .trig_load(trig_load), .trig_capture(trig_capture), .trig_clear(trig_clear),
        .run_en(run_en), .wrap_mode(wrap_mode), .step(step), .prescale(prescale),
        .limit(limit), .load_val(load_val), .count(count),
        .snap_lo(snap_lo), .snap_hi(snap_hi), .snap_seq(snap_seq),
        .ovf_flag(ovf_flag), .unf_flag(unf_flag), .ev_pulse(ev_pulse), .state(state)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [5:0]  trg;
        logic        wrap;
        logic [15:0] stp;
        logic [31:0] lim;
        logic [31:0] lv;
        logic [31:0] e_count;
        logic        e_ovf;
        logic        e_unf;
        logic        e_ev;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] trg, input logic wrap, input logic [15:0] stp,
                                input logic [31:0] lim, input logic [31:0] lv,
                                input logic [31:0] ec, input logic eo, input logic eu,
                                input logic ee);
        vec_t v;
        v.trg = trg; v.wrap = wrap; v.stp = stp; v.lim = lim; v.lv = lv;
        v.e_count = ec; v.e_ovf = eo; v.e_unf = eu; v.e_ev = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] ec, input logic eo,
                              input logic eu, input logic ee, input logic [1:0] es);
        check({tag, " count"}, count, ec);
        check({tag, " ovf"}, 32'(ovf_flag), 32'(eo));
        check({tag, " unf"}, 32'(unf_flag), 32'(eu));
        check({tag, " ev"}, 32'(ev_pulse), 32'(ee));
        check({tag, " state"}, 32'(state), 32'(es));
    endtask

    task automatic clear_pulses();
        trig_reset = 0; trig_up = 0; trig_down = 0;
        trig_load = 0; trig_capture = 0; trig_clear = 0;
    endtask

    // Inputs are set at a negedge; one rising edge is applied and outputs are
    // then observed at the following negedge.
    task automatic cycle();
        @(posedge sys_clk);
        #1;
        clear_pulses();
        @(negedge sys_clk);
    endtask

    initial begin
        int exp_c;
        clear_pulses();
        run_en = 0; wrap_mode = 0; step = 16'd1; prescale = '0;
        limit = 32'd100; load_val = '0;

        repeat (2) @(negedge sys_clk);
        check_outs("reset", 32'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        check("reset snap_lo", 32'(snap_lo), 32'd0);
        check("reset snap_seq", 32'(snap_seq), 32'd0);
        reset_n = 1;
        @(negedge sys_clk);

        // Manual counting, clamping, wrap and saturate, flag set/clear.
        vecs.push_back(mk(T_LD, 0, 16'd7, 32'd100, 32'd0, 32'd0, 0, 0, 0));
        for (int k = 1; k <= 14; k++)
            vecs.push_back(mk(T_UP, 0, 16'd7, 32'd100, 32'd0, 32'(7 * k), 0, 0, 0));
        vecs.push_back(mk(T_UP,        0, 16'd7,   32'd100, 32'd0,  32'd100, 1, 0, 1));
        vecs.push_back(mk(6'b0,        0, 16'd7,   32'd100, 32'd0,  32'd100, 1, 0, 0));
        vecs.push_back(mk(T_UP | T_DN, 0, 16'd7,   32'd100, 32'd0,  32'd100, 1, 0, 0));
        vecs.push_back(mk(T_CLR,       1, 16'd1,   32'd9,   32'd0,  32'd9,   0, 0, 0));
        vecs.push_back(mk(T_LD,        1, 16'd1,   32'd9,   32'd0,  32'd0,   0, 0, 0));
        vecs.push_back(mk(T_DN,        1, 16'd1,   32'd9,   32'd0,  32'd9,   0, 1, 1));
        vecs.push_back(mk(T_DN,        1, 16'd1,   32'd9,   32'd0,  32'd8,   0, 1, 0));
        vecs.push_back(mk(T_LD,        1, 16'd1,   32'd9,   32'd0,  32'd0,   0, 1, 0));
        vecs.push_back(mk(T_CLR | T_DN,1, 16'd1,   32'd9,   32'd0,  32'd9,   0, 1, 1));
        vecs.push_back(mk(T_CLR,       1, 16'd1,   32'd9,   32'd0,  32'd9,   0, 0, 0));
        vecs.push_back(mk(T_UP,        1, 16'd1,   32'd9,   32'd0,  32'd0,   1, 0, 1));
        vecs.push_back(mk(T_CLR,       0, 16'd1,   32'd9,   32'd0,  32'd0,   0, 0, 0));
        vecs.push_back(mk(T_DN,        0, 16'd1,   32'd9,   32'd0,  32'd0,   0, 1, 1));
        vecs.push_back(mk(T_CLR | T_UP,0, 16'd0,   32'd9,   32'd0,  32'd1,   0, 0, 0));
        vecs.push_back(mk(T_LD | T_CLR,0, 16'd1,   32'd50,  32'd80, 32'd50,  0, 0, 0));
        vecs.push_back(mk(6'b0,        0, 16'd1,   32'd20,  32'd80, 32'd20,  0, 0, 0));
        vecs.push_back(mk(T_LD | T_UP, 0, 16'd7,   32'd20,  32'd5,  32'd5,   0, 0, 0));
        vecs.push_back(mk(T_RST | T_UP,0, 16'd7,   32'd20,  32'd5,  32'd0,   0, 0, 0));
        vecs.push_back(mk(T_UP,        0, 16'd100, 32'd20,  32'd5,  32'd20,  1, 0, 1));
        vecs.push_back(mk(T_CLR,       0, 16'd100, 32'd20,  32'd5,  32'd20,  0, 0, 0));

        foreach (vecs[i]) begin
            trig_up      = vecs[i].trg[0];
            trig_down    = vecs[i].trg[1];
            trig_load    = vecs[i].trg[2];
            trig_capture = vecs[i].trg[3];
            trig_clear   = vecs[i].trg[4];
            trig_reset   = vecs[i].trg[5];
            wrap_mode    = vecs[i].wrap;
            step         = vecs[i].stp;
            limit        = vecs[i].lim;
            load_val     = vecs[i].lv;
            cycle();
            check_outs($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_ovf,
                       vecs[i].e_unf, vecs[i].e_ev, 2'b00);
        end

        // Auto-run: prescale 3 gives a tick every 4 cycles; saturating at limit enters HOLD.
        limit = 32'd5; prescale = 24'd3; wrap_mode = 0; load_val = 32'd0; trig_load = 1;
        cycle();
        check_outs("autorun load", 32'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        run_en = 1;
        for (int n = 1; n <= 30; n++) begin
            cycle();
            exp_c = (n - 1) / 4;
            if (exp_c > 5) exp_c = 5;
            check_outs($sformatf("auto n%0d", n), 32'(exp_c), (n >= 25), 1'b0, (n == 25),
                       (n >= 25) ? 2'b10 : 2'b01);
        end
        run_en = 0;
        cycle();
        check_outs("hold to idle", 32'd5, 1'b1, 1'b0, 1'b0, 2'b00);

        // Snapshot: atomic halves of the pre-update count, sequence counter wrap.
        limit = 32'hFFFF_FFFF; load_val = 32'h0001_FFFF; trig_load = 1; trig_clear = 1;
        cycle();
        check("snap load count", count, 32'h0001_FFFF);
        step = 16'd1; trig_capture = 1; trig_up = 1;
        cycle();
        check("cap count", count, 32'h0002_0000);
        check("cap snap_hi", 32'(snap_hi), 32'h0001);
        check("cap snap_lo", 32'(snap_lo), 32'hFFFF);
        check("cap seq", 32'(snap_seq), 32'd1);
        for (int k = 0; k < 256; k++) begin
            trig_capture = 1;
            cycle();
        end
        check("seq wrap", 32'(snap_seq), 32'd1);
        check("seq wrap snap_hi", 32'(snap_hi), 32'h0002);
        check("seq wrap snap_lo", 32'(snap_lo), 32'h0000);
        trig_capture = 1; trig_reset = 1;
        cycle();
        check("rst cap count", count, 32'd0);
        check("rst cap snap_hi", 32'(snap_hi), 32'h0002);
        check("rst cap seq", 32'(snap_seq), 32'd2);

        // Asynchronous reset mid-run, observed before any further clock edge.
        load_val = 32'h0000_1234; trig_load = 1; prescale = 24'd100;
        cycle();
        check("pre-reset count", count, 32'h0000_1234);
        run_en = 1;
        cycle();
        cycle();
        check("pre-reset state", 32'(state), 32'd1);
        #2;
        reset_n = 0;
        #1;
        check_outs("async reset", 32'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        check("async reset snap_hi", 32'(snap_hi), 32'd0);
        check("async reset snap_lo", 32'(snap_lo), 32'd0);
        check("async reset seq", 32'(snap_seq), 32'd0);
        @(negedge sys_clk);
        run_en = 0;
        reset_n = 1;
        @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
